// File: rtl/pattern_game_ctrl.sv
// pattern_game_ctrl: sequencer for a pattern memorization game.
// A round generates a pseudo-random LED pattern, plays it back, collects the
// player's presses, and ends in WIN or LOSE.
//
// Ports:
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset
//   blink_tick_i one-cycle strobe at blink rate
//   start_i      one-cycle request to begin a round
//   len_cfg_i    requested pattern length (clamped to 1..MAX_LEN)
//   seed_i       LFSR seed, latched on an accepted start (0 -> 16'hACE1)
//   btn_i        one-cycle debounced press pulses
//   led_o        LED drive
//   busy_o       high from accepted start until WIN/LOSE
//   win_o        held high in WIN
//   lose_o       held high in LOSE
//   step_o       current pattern index
//
// Optional feature macro: PLAYER_ECHO_EN
//   When defined, a correct press lights its LED until the next blink tick or press.
//
// state    | meaning
// ---------+-------------------------------------------------
// IDLE     | after reset, waiting for start
// GEN      | fill one pattern entry per cycle from the LFSR
// SHOW_ON  | current entry lit for ON_TICKS blink ticks
// SHOW_OFF | all LEDs dark for one blink tick
// INPUT    | compare presses against the pattern, with timeout
// WIN      | whole pattern entered correctly
// LOSE     | wrong press or timeout
module pattern_game_ctrl #(
  parameter int NUM_LEDS      = 4,
  parameter int MAX_LEN       = 16,
  parameter int ON_TICKS      = 2,
  parameter int TIMEOUT_TICKS = 20
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       blink_tick_i,
  input  logic                       start_i,
  input  logic [$clog2(MAX_LEN):0]   len_cfg_i,
  input  logic [15:0]                seed_i,
  input  logic [NUM_LEDS-1:0]        btn_i,
  output logic [NUM_LEDS-1:0]        led_o,
  output logic                       busy_o,
  output logic                       win_o,
  output logic                       lose_o,
  output logic [$clog2(MAX_LEN)-1:0] step_o
);

  localparam int SW   = $clog2(MAX_LEN);
  localparam int LW   = SW + 1;
  localparam int IW   = $clog2(NUM_LEDS);
  localparam int CMAX = (TIMEOUT_TICKS > ON_TICKS) ? TIMEOUT_TICKS : ON_TICKS;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_GEN, S_SHOW_ON, S_SHOW_OFF, S_INPUT, S_WIN, S_LOSE
  } state_e;

  state_e              state_q, state_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [LW-1:0]       len_q, len_d;
  logic [SW-1:0]       step_q, step_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       pat_q [MAX_LEN];
  logic [IW-1:0]       pat_d [MAX_LEN];
  logic [NUM_LEDS-1:0] led_q, led_d;
  logic                busy_q, busy_d, win_q, win_d, lose_q, lose_d;
  logic [NUM_LEDS-1:0] echo_q, echo_d;
  logic                last;
  logic [NUM_LEDS-1:0] exp_oh;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [NUM_LEDS-1:0] onehot(input logic [IW-1:0] idx);
    return NUM_LEDS'(1) << idx;
  endfunction

  assign last   = ({1'b0, step_q} == (len_q - LW'(1)));
  assign exp_oh = onehot(pat_q[step_q]);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      lfsr_q  <= '0;
      len_q   <= '0;
      step_q  <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < MAX_LEN; i++) pat_q[i] <= '0;
      led_q   <= '0;
      busy_q  <= 1'b0;
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
      echo_q  <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      len_q   <= len_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      win_q   <= win_d;
      lose_q  <= lose_d;
      echo_q  <= echo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    len_d   = len_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    echo_d  = '0;
    case (state_q)
      S_IDLE, S_WIN, S_LOSE: begin
        if (start_i) begin
          state_d = S_GEN;
          step_d  = '0;
          lfsr_d  = (seed_i == 16'h0000) ? 16'hACE1 : seed_i;
          if (len_cfg_i == '0)                 len_d = LW'(1);
          else if (len_cfg_i > LW'(MAX_LEN))   len_d = LW'(MAX_LEN);
          else                                 len_d = len_cfg_i;
        end
      end
      S_GEN: begin
        lfsr_d        = lfsr_next(lfsr_q);
        pat_d[step_q] = lfsr_d[IW-1:0];
        if (last) begin
          step_d  = '0;
          cnt_d   = CW'(ON_TICKS);
          state_d = S_SHOW_ON;
        end else begin
          step_d = step_q + SW'(1);
        end
      end
      S_SHOW_ON: begin
        if (blink_tick_i) begin
          if (cnt_q == CW'(1)) state_d = S_SHOW_OFF;
          else                 cnt_d   = cnt_q - CW'(1);
        end
      end
      S_SHOW_OFF: begin
        if (blink_tick_i) begin
          if (last) begin
            step_d  = '0;
            cnt_d   = CW'(TIMEOUT_TICKS);
            state_d = S_INPUT;
          end else begin
            step_d  = step_q + SW'(1);
            cnt_d   = CW'(ON_TICKS);
            state_d = S_SHOW_ON;
          end
        end
      end
      S_INPUT: begin
        echo_d = echo_q;
        // A press wins over a coincident tick; the tick is simply dropped.
        if (btn_i != '0) begin
          echo_d = '0;
          if (btn_i == exp_oh) begin
            if (last) begin
              state_d = S_WIN;
            end else begin
              step_d = step_q + SW'(1);
              cnt_d  = CW'(TIMEOUT_TICKS);
              echo_d = btn_i;
            end
          end else begin
            state_d = S_LOSE;
          end
        end else if (blink_tick_i) begin
          echo_d = '0;
          if (cnt_q == CW'(1)) state_d = S_LOSE;
          else                 cnt_d   = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    led_d  = '0;
    busy_d = 1'b0;
    win_d  = 1'b0;
    lose_d = 1'b0;
    case (state_d)
      S_GEN, S_SHOW_OFF: busy_d = 1'b1;
      S_SHOW_ON: begin
        busy_d = 1'b1;
        led_d  = onehot(pat_d[step_d]);
      end
      S_INPUT: begin
        busy_d = 1'b1;
`ifdef PLAYER_ECHO_EN
        led_d  = echo_d;
`else
        led_d  = '0;
`endif
      end
      S_WIN: begin
        win_d = 1'b1;
        led_d = '1;
      end
      S_LOSE:  lose_d = 1'b1;
      default: led_d  = '0;
    endcase
  end

  assign led_o  = led_q;
  assign busy_o = busy_q;
  assign win_o  = win_q;
  assign lose_o = lose_q;
  assign step_o = step_q;

endmodule

// File: tb/tb_pattern_game_ctrl.sv
module tb_pattern_game_ctrl;
  localparam int NL  = 4;
  localparam int ML  = 16;
  localparam int ONT = 2;
  localparam int TOT = 20;
`ifdef PLAYER_ECHO_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  len_cfg = '0;
  logic [15:0] seed = '0;
  logic [3:0]  btn = '0;
  logic [3:0]  led;
  logic        busy, win, lose;
  logic [3:0]  step;

  int n_chk = 0;
  int n_fail = 0;
  int pat [ML];
  int exp_n;
  logic [3:0] echo;

  always #5 clk = ~clk;

  pattern_game_ctrl #(.NUM_LEDS(NL), .MAX_LEN(ML), .ON_TICKS(ONT), .TIMEOUT_TICKS(TOT)) dut (
    .clk_i(clk), .rst_ni(rst_n), .blink_tick_i(tick), .start_i(start),
    .len_cfg_i(len_cfg), .seed_i(seed), .btn_i(btn),
    .led_o(led), .busy_o(busy), .win_o(win), .lose_o(lose), .step_o(step)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] el, input logic eb,
                         input logic ew, input logic elo, input int es);
    chk({tag, ".led"}, 32'(led), 32'(el));
    chk({tag, ".busy"}, 32'(busy), 32'(eb));
    chk({tag, ".win"}, 32'(win), 32'(ew));
    chk({tag, ".lose"}, 32'(lose), 32'(elo));
    if (es >= 0) chk({tag, ".step"}, 32'(step), 32'(es));
  endtask

  function automatic logic [3:0] oh(input int i);
    return 4'(1 << i);
  endfunction

  // Expected pattern: clamp the length, then step the Galois LFSR once per entry.
  task automatic gen_pat(input logic [15:0] sd, input logic [4:0] lc);
    logic [15:0] l;
    exp_n = (lc == 0) ? 1 : ((int'(lc) > ML) ? ML : int'(lc));
    l = (sd == 16'h0) ? 16'hACE1 : sd;
    for (int i = 0; i < exp_n; i++) begin
      l = (l >> 1) ^ ((l % 2 == 1) ? 16'hB400 : 16'h0);
      pat[i] = int'(l) % NL;
    end
  endtask

  task automatic cyc(input logic t, input logic [3:0] b, input logic s);
    tick = t; btn = b; start = s;
    @(posedge clk); #1;
    tick = 0; btn = 0; start = 0;
  endtask

  // Idle cycles while busy: buttons and start requests must be ignored.
  task automatic gap_show(input int i, input logic [3:0] eled);
    repeat ($urandom_range(0, 2)) begin
      seed = 16'($urandom); len_cfg = 5'($urandom);
      cyc(1'b0, 4'($urandom), $urandom_range(0, 3) == 0);
      chk_out("show_hold", eled, 1'b1, 1'b0, 1'b0, i);
    end
  endtask

  task automatic gap_in(input int i);
    repeat ($urandom_range(0, 2)) begin
      seed = 16'($urandom); len_cfg = 5'($urandom);
      cyc(1'b0, 4'h0, $urandom_range(0, 3) == 0);
      chk_out("in_hold", ECHO ? echo : 4'h0, 1'b1, 1'b0, 1'b0, i);
    end
  endtask

  task automatic hold_end(input logic [3:0] el, input logic ew, input logic elo);
    repeat (2) begin
      cyc(1'($urandom), 4'($urandom), 1'b0);
      chk_out("end_hold", el, 1'b0, ew, elo, -1);
    end
  endtask

  task automatic start_and_gen(input logic [15:0] sd, input logic [4:0] lc);
    gen_pat(sd, lc);
    seed = sd; len_cfg = lc;
    cyc(1'b0, 4'h0, 1'b1);
    chk_out("start", 4'h0, 1'b1, 1'b0, 1'b0, 0);
    for (int c = 1; c <= exp_n; c++) begin
      cyc(1'($urandom), 4'($urandom), 1'b0);
      if (c < exp_n) chk("gen_led", 32'(led), 32'h0);
      else chk_out("show0", oh(pat[0]), 1'b1, 1'b0, 1'b0, 0);
    end
  endtask

  // mode 0: all correct; 1: wrong single/any press; 2: timeout; 3: multi-bit press
  task automatic play_round(input logic [15:0] sd, input logic [4:0] lc, input int mode);
    int kfail, klong, m;
    logic [3:0] b;
    start_and_gen(sd, lc);
    for (int i = 0; i < exp_n; i++) begin
      for (int t = 1; t <= ONT; t++) begin
        gap_show(i, oh(pat[i]));
        cyc(1'b1, 4'($urandom), 1'b0);
        if (t < ONT) chk_out("on_tick", oh(pat[i]), 1'b1, 1'b0, 1'b0, i);
        else chk_out("on_end", 4'h0, 1'b1, 1'b0, 1'b0, i);
      end
      gap_show(i, 4'h0);
      cyc(1'b1, 4'($urandom), 1'b0);
      if (i < exp_n - 1) chk_out("off_end", oh(pat[i+1]), 1'b1, 1'b0, 1'b0, i + 1);
      else chk_out("to_input", 4'h0, 1'b1, 1'b0, 1'b0, 0);
    end
    kfail = $urandom_range(0, exp_n - 1);
    klong = $urandom_range(0, exp_n - 1);
    echo = 4'h0;
    for (int i = 0; i < exp_n; i++) begin
      m = (i == klong) ? TOT - 1 : $urandom_range(0, 2);
      if (mode == 2 && i == kfail) m = TOT;
      for (int j = 1; j <= m; j++) begin
        gap_in(i);
        cyc(1'b1, 4'h0, 1'b0);
        echo = 4'h0;
        if (j == TOT) begin
          chk_out("timeout", 4'h0, 1'b0, 1'b0, 1'b1, -1);
          hold_end(4'h0, 1'b0, 1'b1);
          return;
        end
        chk_out("in_tick", 4'h0, 1'b1, 1'b0, 1'b0, i);
      end
      gap_in(i);
      if ((mode == 1 || mode == 3) && i == kfail) begin
        if (mode == 3) b = oh(pat[i]) | oh((pat[i] + 1) % NL);
        else begin
          do b = 4'($urandom_range(1, 15)); while (b == oh(pat[i]));
        end
        cyc(1'($urandom), b, 1'b0);
        chk_out("wrong", 4'h0, 1'b0, 1'b0, 1'b1, -1);
        hold_end(4'h0, 1'b0, 1'b1);
        return;
      end
      cyc((m == TOT - 1) ? 1'b1 : 1'($urandom), oh(pat[i]), 1'b0);
      if (i == exp_n - 1) begin
        chk_out("win", 4'hF, 1'b0, 1'b1, 1'b0, -1);
        hold_end(4'hF, 1'b1, 1'b0);
      end else begin
        echo = oh(pat[i]);
        chk_out("press_ok", ECHO ? echo : 4'h0, 1'b1, 1'b0, 1'b0, i + 1);
      end
    end
  endtask

  initial begin
    #1;
    chk_out("rst", 4'h0, 1'b0, 1'b0, 1'b0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(1'b1, 4'hF, 1'b0);
    chk_out("idle", 4'h0, 1'b0, 1'b0, 1'b0, 0);

    play_round(16'h0001, 5'd3, 0);
    play_round(16'h0001, 5'd3, 1);
    play_round(16'h0001, 5'd3, 3);
    play_round(16'h1234, 5'd0, 0);
    play_round(16'hBEEF, 5'd31, 0);
    play_round(16'h0000, 5'd5, 2);
    play_round(16'h0ACE, 5'd16, 3);

    // Asynchronous reset while a pattern entry is lit.
    start_and_gen(16'h5A5A, 5'd4);
    #2 rst_n = 1'b0;
    #1 chk_out("async_rst", 4'h0, 1'b0, 1'b0, 1'b0, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(1'b1, 4'hF, 1'b0);
    chk_out("post_rst", 4'h0, 1'b0, 1'b0, 1'b0, 0);

    for (int r = 0; r < 16; r++)
      play_round(16'($urandom), 5'($urandom_range(0, 20)), $urandom_range(0, 3));

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
